// File: rtl/shift_exec_pipe_pkg.sv
// Shared definitions for the shift execution pipe: operation encodings and default widths.
package shift_exec_pipe_pkg;

  localparam int DEF_OPERAND_WIDTH  = 16;
  localparam int DEF_SHAMT_WIDTH    = 4;
  localparam int DEF_NUM_OPERATIONS = 2;
  localparam int DEF_DEPTH          = 4;

  typedef enum logic [1:0] {
    OP_ROL = 2'b00,
    OP_SLL = 2'b01,
    OP_ROR = 2'b10,
    OP_SRL = 2'b11
  } shift_op_e;

endpackage

// File: rtl/shift_barrel.sv
// Combinational barrel shifter: rotate left/right (amount modulo width) and zero-filling shifts.
module shift_barrel
  import shift_exec_pipe_pkg::*;
#(
  parameter int W  = DEF_OPERAND_WIDTH,
  parameter int SW = DEF_SHAMT_WIDTH
) (
  input  logic [W-1:0]  data_i,
  input  logic [SW-1:0] shamt_i,
  input  logic [1:0]    op_i,
  output logic [W-1:0]  data_o
);

  logic [31:0]  rot_amt;
  logic [31:0]  sh_amt;
  logic [W-1:0] rol_res;
  logic [W-1:0] ror_res;

  assign sh_amt  = 32'(shamt_i);
  assign rot_amt = sh_amt % 32'(W);
  // A zero rotate shifts the complementary half by W, which yields zero and leaves data intact.
  assign rol_res = (data_i << rot_amt) | (data_i >> (32'(W) - rot_amt));
  assign ror_res = (data_i >> rot_amt) | (data_i << (32'(W) - rot_amt));

  always_comb begin
    data_o = data_i;
    case (shift_op_e'(op_i))
      OP_ROL:  data_o = rol_res;
      OP_SLL:  data_o = data_i << sh_amt;
      OP_ROR:  data_o = ror_res;
      OP_SRL:  data_o = data_i >> sh_amt;
      default: data_o = data_i;
    endcase
  end

endmodule

// File: rtl/shift_req_fifo.sv
// Request FIFO: power-of-two depth, combinational head read, occupancy count and full/empty flags.
module shift_req_fifo
  import shift_exec_pipe_pkg::*;
#(
  parameter int WIDTH = 22,
  parameter int DEPTH = DEF_DEPTH
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push_i,
  input  logic                     pop_i,
  input  logic [WIDTH-1:0]         wdata_i,
  output logic [WIDTH-1:0]         rdata_o,
  output logic [$clog2(DEPTH):0]   count_o,
  output logic                     full_o,
  output logic                     empty_o
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW:0]      count_q, count_d;
  logic             do_push, do_pop;

  assign full_o  = (count_q == (AW+1)'(DEPTH));
  assign empty_o = (count_q == '0);
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;
  assign rdata_o = mem[rd_ptr_q];
  assign count_o = count_q;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    // Pointer width equals log2(DEPTH), so the increment wraps modulo DEPTH.
    if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && do_push) mem[wr_ptr_q] <= wdata_i;
  end

endmodule

// File: rtl/shift_exec_pipe.sv
// Shift execution pipe: request FIFO feeding a barrel shifter into a valid/ready result register.
module shift_exec_pipe
  import shift_exec_pipe_pkg::*;
#(
  parameter int OPERAND_WIDTH  = DEF_OPERAND_WIDTH,
  parameter int SHAMT_WIDTH    = DEF_SHAMT_WIDTH,
  parameter int NUM_OPERATIONS = DEF_NUM_OPERATIONS,
  parameter int DEPTH          = DEF_DEPTH
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [OPERAND_WIDTH-1:0]  In,
  input  logic [SHAMT_WIDTH-1:0]    ShAmt,
  input  logic [NUM_OPERATIONS-1:0] Oper,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [OPERAND_WIDTH-1:0]  Out,
  output logic [$clog2(DEPTH):0]    count
);

  localparam int REQ_W = OPERAND_WIDTH + SHAMT_WIDTH + NUM_OPERATIONS;

  logic [REQ_W-1:0]          head;
  logic [OPERAND_WIDTH-1:0]  head_in;
  logic [SHAMT_WIDTH-1:0]    head_shamt;
  logic [NUM_OPERATIONS-1:0] head_oper;
  logic [OPERAND_WIDTH-1:0]  shift_res;
  logic                      fifo_full, fifo_empty;
  logic                      push, pop;
  logic                      out_valid_q, out_valid_d;
  logic [OPERAND_WIDTH-1:0]  out_q, out_d;

  // Full is judged on registered occupancy, so a pop never frees a slot in the same cycle.
  assign in_ready = !fifo_full;
  assign push     = in_valid && in_ready;
  assign pop      = !fifo_empty && (!out_valid_q || out_ready);
  assign {head_in, head_shamt, head_oper} = head;

  shift_req_fifo #(
    .WIDTH (REQ_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (push),
    .pop_i   (pop),
    .wdata_i ({In, ShAmt, Oper}),
    .rdata_o (head),
    .count_o (count),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  shift_barrel #(
    .W  (OPERAND_WIDTH),
    .SW (SHAMT_WIDTH)
  ) u_barrel (
    .data_i  (head_in),
    .shamt_i (head_shamt),
    .op_i    (head_oper[1:0]),
    .data_o  (shift_res)
  );

  always_comb begin
    out_valid_d = out_valid_q;
    out_d       = out_q;
    if (pop) begin
      out_valid_d = 1'b1;
      out_d       = shift_res;
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      out_q       <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      out_q       <= out_d;
    end
  end

  assign out_valid = out_valid_q;
  assign Out       = out_q;

endmodule

// File: tb/tb_shift_exec_pipe.sv
// Directed bench for shift_exec_pipe: hand-computed vectors covering ops, backpressure, reset and streaming.
module tb_shift_exec_pipe;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] In;
  logic [3:0]  ShAmt;
  logic [1:0]  Oper;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] Out;
  logic [2:0]  count;

  int n_vec  = 0;
  int n_miss = 0;

  shift_exec_pipe dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .In        (In),
    .ShAmt     (ShAmt),
    .Oper      (Oper),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .Out       (Out),
    .count     (count)
  );

  always #5 clk = ~clk;

  task automatic check_vec(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end else begin
      $display("ok   %s: %0h", tag, obs);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [15:0] d, input logic [3:0] s, input logic [1:0] o);
    in_valid = v;
    In       = d;
    ShAmt    = s;
    Oper     = o;
  endtask

  // Single request with out_ready high; result must be visible one edge after acceptance.
  task automatic single(input string tag, input logic [15:0] d, input logic [3:0] s,
                        input logic [1:0] o, input logic [15:0] exp);
    drive(1'b1, d, s, o);
    step();
    drive(1'b0, 16'h0, 4'h0, 2'b00);
    check_vec({tag, "_lat"}, 32'(out_valid), 32'd0);
    step();
    check_vec({tag, "_valid"}, 32'(out_valid), 32'd1);
    check_vec({tag, "_out"}, 32'(Out), 32'(exp));
    step();
  endtask

  logic [15:0] bp_in  [6] = '{16'h0001, 16'h0001, 16'h0003, 16'h8000, 16'h1234, 16'hFFFF};
  logic [3:0]  bp_sh  [6] = '{4'd1, 4'd2, 4'd1, 4'd15, 4'd4, 4'd3};
  logic [1:0]  bp_op  [6] = '{2'b00, 2'b01, 2'b10, 2'b11, 2'b00, 2'b11};
  logic [15:0] bp_exp [6] = '{16'h0002, 16'h0004, 16'h8001, 16'h0001, 16'h2341, 16'h1FFF};

  logic [15:0] st_in  [8] = '{16'hABCD, 16'hABCD, 16'hABCD, 16'hABCD,
                              16'h8001, 16'h00F0, 16'h1234, 16'hF00F};
  logic [3:0]  st_sh  [8] = '{4'd4, 4'd4, 4'd4, 4'd4, 4'd15, 4'd12, 4'd8, 4'd7};
  logic [1:0]  st_op  [8] = '{2'b00, 2'b10, 2'b01, 2'b11, 2'b00, 2'b01, 2'b10, 2'b11};
  logic [15:0] st_exp [8] = '{16'hBCDA, 16'hDABC, 16'hBCD0, 16'h0ABC,
                              16'hC000, 16'h0000, 16'h3412, 16'h01E0};

  initial begin
    int accepted;
    rst       = 1'b1;
    out_ready = 1'b1;
    drive(1'b0, 16'h0, 4'h0, 2'b00);
    step();
    step();
    rst = 1'b0;
    check_vec("rst_out_valid", 32'(out_valid), 32'd0);
    check_vec("rst_out", 32'(Out), 32'd0);
    check_vec("rst_count", 32'(count), 32'd0);
    check_vec("rst_in_ready", 32'(in_ready), 32'd1);

    // Basic latency and hold-after-drain behaviour.
    drive(1'b1, 16'h8001, 4'd1, 2'b00);
    step();
    drive(1'b0, 16'h0, 4'h0, 2'b00);
    check_vec("rol1_count", 32'(count), 32'd1);
    check_vec("rol1_lat", 32'(out_valid), 32'd0);
    step();
    check_vec("rol1_valid", 32'(out_valid), 32'd1);
    check_vec("rol1_out", 32'(Out), 32'h0003);
    check_vec("rol1_count0", 32'(count), 32'd0);
    step();
    check_vec("rol1_clear", 32'(out_valid), 32'd0);
    check_vec("rol1_keep", 32'(Out), 32'h0003);

    single("srl4", 16'hF000, 4'd4, 2'b11, 16'h0F00);
    single("sll8", 16'h00FF, 4'd8, 2'b01, 16'hFF00);
    single("ror1", 16'h0001, 4'd1, 2'b10, 16'h8000);
    for (int i = 0; i < 4; i++) begin
      single($sformatf("zero_op%0d", i), 16'hA5C3, 4'd0, 2'(i), 16'hA5C3);
    end

    // Backpressure: six requests with consumer stalled; only five fit.
    out_ready = 1'b0;
    accepted  = 0;
    for (int i = 0; i < 6; i++) begin
      drive(1'b1, bp_in[i], bp_sh[i], bp_op[i]);
      if (in_ready) accepted++;
      step();
    end
    drive(1'b0, 16'h0, 4'h0, 2'b00);
    check_vec("bp_accepted", 32'(accepted), 32'd5);
    check_vec("bp_count", 32'(count), 32'd4);
    check_vec("bp_in_ready", 32'(in_ready), 32'd0);
    check_vec("bp_valid", 32'(out_valid), 32'd1);
    check_vec("bp_head", 32'(Out), 32'(bp_exp[0]));
    step();
    step();
    check_vec("bp_stable", 32'(Out), 32'(bp_exp[0]));
    check_vec("bp_stable_cnt", 32'(count), 32'd4);
    out_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      check_vec($sformatf("bp_res%0d_valid", i), 32'(out_valid), 32'd1);
      check_vec($sformatf("bp_res%0d", i), 32'(Out), 32'(bp_exp[i]));
      step();
    end
    check_vec("bp_drained", 32'(out_valid), 32'd0);
    check_vec("bp_drained_cnt", 32'(count), 32'd0);

    // Reset with three queued entries plus a held result; a request on the reset edge is dropped.
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, st_in[i], st_sh[i], st_op[i]);
      step();
    end
    check_vec("pre_rst_count", 32'(count), 32'd3);
    check_vec("pre_rst_valid", 32'(out_valid), 32'd1);
    drive(1'b1, 16'h1111, 4'd1, 2'b00);
    rst = 1'b1;
    step();
    rst = 1'b0;
    drive(1'b0, 16'h0, 4'h0, 2'b00);
    check_vec("mid_rst_valid", 32'(out_valid), 32'd0);
    check_vec("mid_rst_count", 32'(count), 32'd0);
    check_vec("mid_rst_ready", 32'(in_ready), 32'd1);
    check_vec("mid_rst_out", 32'(Out), 32'd0);
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      check_vec($sformatf("post_rst_quiet%0d", i), 32'(out_valid), 32'd0);
    end

    // Streaming: one request per cycle, one result per cycle, occupancy stays at one.
    for (int c = 0; c < 9; c++) begin
      if (c < 8) drive(1'b1, st_in[c], st_sh[c], st_op[c]);
      else       drive(1'b0, 16'h0, 4'h0, 2'b00);
      step();
      if (c < 8) check_vec($sformatf("st_count%0d", c), 32'(count), 32'd1);
      if (c >= 1) begin
        check_vec($sformatf("st_valid%0d", c - 1), 32'(out_valid), 32'd1);
        check_vec($sformatf("st_res%0d", c - 1), 32'(Out), 32'(st_exp[c - 1]));
      end
    end
    check_vec("st_last", 32'(Out), 32'(st_exp[7]));
    step();
    check_vec("st_done", 32'(out_valid), 32'd0);
    check_vec("st_done_cnt", 32'(count), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
